// File: rtl/fifo_valid_ready_pkg.sv
// Shared defaults and parameter-legality helpers for the valid/ready FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_valid_ready_pkg;

    localparam int DEF_DWIDTH   = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_AFULL_TH = 3;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return is_pow2(depth) && (depth >= 2);
    endfunction

    function automatic bit afull_ok(input int th, input int depth);
        return (th >= 1) && (th <= depth);
    endfunction

endpackage

// File: rtl/fifo_valid_ready_mem.sv
// DEPTH x DWIDTH register array, synchronous write / asynchronous read.
// Latency: write visible on read port the cycle after we.
// Backpressure: none; the caller gates we.
module fifo_valid_ready_mem
    import fifo_valid_ready_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DWIDTH-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DWIDTH-1:0]        rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_valid_ready.sv
// First-word-fall-through FIFO with valid/ready on both sides.
// Latency: a word pushed at edge N appears on out_valid/out_data after edge N.
// Backpressure: in_ready = !full from registered pointers only; never sees out_ready.
module fifo_valid_ready
    import fifo_valid_ready_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AFULL_TH = DEF_AFULL_TH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DWIDTH-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DWIDTH-1:0]      out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // MSB is the wrap bit: equal low bits with differing wrap bits means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign almost_full = (count >= PW'(AFULL_TH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + PW'(1);
            end else if (pop && !push) begin
                count <= count - PW'(1);
            end
        end
    end

    fifo_valid_ready_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (in_data),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (out_data)
    );

`ifndef SYNTHESIS
    a_params_legal: assert property (@(posedge clk)
        depth_ok(DEPTH) && afull_ok(AFULL_TH, DEPTH));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !full);

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        count <= PW'(DEPTH));

    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        count == PW'(wr_ptr - rd_ptr));
`endif

endmodule

// File: tb/tb_fifo_valid_ready.sv
// Directed + randomized bench for fifo_valid_ready against a queue-based model.
module tb_fifo_valid_ready;

    localparam int DWIDTH   = 8;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_ready;
    logic [2:0]        count;
    logic              almost_full;

    fifo_valid_ready #(
        .DWIDTH   (DWIDTH),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [DWIDTH-1:0] model[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/in_ready"},    32'(in_ready),    32'(model.size() < DEPTH));
        chk({tag, "/out_valid"},   32'(out_valid),   32'(model.size() > 0));
        chk({tag, "/count"},       32'(count),       32'(model.size()));
        chk({tag, "/almost_full"}, 32'(almost_full), 32'(model.size() >= AFULL_TH));
        if (model.size() > 0) begin
            chk({tag, "/out_data"}, 32'(out_data), 32'(model[0]));
        end
    endtask

    // One clock: drive inputs, predict the handshakes from the model, advance, compare.
    task automatic step(input string tag, input logic v, input logic [DWIDTH-1:0] d,
                        input logic r);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        do_push = v && (model.size() < DEPTH);
        do_pop  = r && (model.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) begin
            void'(model.pop_front());
        end
        if (do_push) begin
            model.push_back(d);
        end
        check_outputs(tag);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        // Reset held for 3 cycles, then idle.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs("in_reset");
        end
        rst_n = 1'b1;
        step("idle", 1'b0, 8'h00, 1'b0);

        // Fill to full with the consumer stalled.
        step("fill1", 1'b1, 8'h11, 1'b0);
        step("fill2", 1'b1, 8'h22, 1'b0);
        step("fill3", 1'b1, 8'h33, 1'b0);
        chk("fill3/af_const", 32'(almost_full), 32'd1);
        step("fill4", 1'b1, 8'h44, 1'b0);
        chk("fill4/in_ready_const", 32'(in_ready), 32'd0);
        chk("fill4/head_const", 32'(out_data), 32'h11);

        // Drain; each step checks the head against the model order.
        chk("drain/head0", 32'(out_data), 32'h11);
        repeat (4) step("drain", 1'b0, 8'h00, 1'b1);
        chk("drain/wr_ptr_wrapped", 32'(dut.wr_ptr), 32'h4);
        chk("drain/rd_ptr_wrapped", 32'(dut.rd_ptr), 32'h4);

        // Full with simultaneous pop: the push is refused this cycle.
        for (int i = 0; i < 4; i++) step("refill", 1'b1, 8'(8'h61 + i), 1'b0);
        step("full_pop", 1'b1, 8'h55, 1'b1);
        chk("full_pop/count_const", 32'(count), 32'd3);
        step("full_push55", 1'b1, 8'h55, 1'b0);
        chk("full_push55/count_const", 32'(count), 32'd4);
        repeat (4) step("drain2", 1'b0, 8'h00, 1'b1);

        // Streaming: occupancy settles at 1, one word per cycle in order.
        for (int i = 0; i < 100; i++) begin
            step("stream", 1'b1, 8'(i), 1'b1);
            chk("stream/count1", 32'(count), 32'd1);
            chk("stream/order", 32'(out_data), 32'(i));
        end
        step("stream_tail", 1'b0, 8'h00, 1'b1);

        // Dropped in_valid with changing data must not write.
        step("novalid", 1'b0, 8'hEE, 1'b0);

        // Randomized traffic: producer-heavy, then consumer-heavy.
        for (int i = 0; i < 300; i++) begin
            step("rand_a", ($urandom_range(0, 9) < 8), 8'($urandom), ($urandom_range(0, 9) < 3));
        end
        for (int i = 0; i < 300; i++) begin
            step("rand_b", ($urandom_range(0, 9) < 3), 8'($urandom), ($urandom_range(0, 9) < 8));
        end
        while (model.size() > 0) step("rand_drain", 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-burst, between edges.
        for (int i = 0; i < 3; i++) step("pre_arst", 1'b1, 8'(8'hC0 + i), 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model.delete();
        check_outputs("arst_immediate");
        chk("arst/count_const", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_arst", 1'b1, 8'hA5, 1'b0);
        chk("post_arst/data_const", 32'(out_data), 32'hA5);
        step("post_arst_pop", 1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
